// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared helpers for the dual-clock FIFO
// Gray/binary conversion works on a 32-bit carrier; callers size-cast to their pointer width.
package async_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic int unsigned fifo_depth(input int unsigned addr_lines);
        return 32'd1 << addr_lines;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended Gray codes convert correctly: the prefix XOR starts from zero bits.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// rtl/async_fifo_sync2.sv - two-flop synchronizer for Gray-coded pointers
// Resets to zero with the destination-domain reset.
module async_fifo_sync2 #(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - dual-clock first-word-fall-through FIFO with Gray pointer crossing
// Status flags are computed from the synchronized (lagging) opposite pointer, so they are pessimistic.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_LINES = 8,
    parameter int ADDR_LINES = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  winc,
    input  logic [DATA_LINES-1:0] wdata,
    output logic                  wfull,
    output logic                  half_full,
    input  logic                  rinc,
    output logic [DATA_LINES-1:0] rdata,
    output logic                  rempty,
    output logic                  half_empty
);

    localparam int A     = ADDR_LINES;
    localparam int PW    = A + 1;
    localparam int DEPTH = int'(fifo_depth(A));
    localparam logic [PW-1:0] HALF = PW'(DEPTH / 2);

    logic [DATA_LINES-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_wfull;
    logic          r_half_full;
    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rgray;
    logic          r_rempty;
    logic          r_half_empty;

    logic          w_wpush;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rq2;
    logic [PW-1:0] w_rq2_bin;
    logic [PW-1:0] w_wlevel;
    logic          w_wfull_next;
    logic          w_half_full_next;

    logic          w_rpop;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wq2;
    logic [PW-1:0] w_wq2_bin;
    logic [PW-1:0] w_rlevel;
    logic          w_rempty_next;
    logic          w_half_empty_next;

    async_fifo_sync2 #(.WIDTH(PW)) u_sync_r2w (
        .i_clk   (wclk),
        .i_rst_n (wrst),
        .i_d     (r_rgray),
        .o_q     (w_rq2)
    );

    async_fifo_sync2 #(.WIDTH(PW)) u_sync_w2r (
        .i_clk   (rclk),
        .i_rst_n (rrst),
        .i_d     (r_wgray),
        .o_q     (w_wq2)
    );

    // Write domain
    always_comb begin
        w_wpush          = winc && !r_wfull;
        w_wbin_next      = r_wbin + PW'(w_wpush);
        w_wgray_next     = PW'(bin2gray(32'(w_wbin_next)));
        w_rq2_bin        = PW'(gray2bin(32'(w_rq2)));
        w_wlevel         = w_wbin_next - w_rq2_bin;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        w_wfull_next     = (w_wgray_next == {~w_rq2[A:A-1], w_rq2[A-2:0]});
        w_half_full_next = (w_wlevel >= HALF);
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_wbin      <= '0;
            r_wgray     <= '0;
            r_wfull     <= 1'b0;
            r_half_full <= 1'b0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wgray     <= w_wgray_next;
            r_wfull     <= w_wfull_next;
            r_half_full <= w_half_full_next;
        end
    end

    always_ff @(posedge wclk) begin
        if (w_wpush) begin
            r_mem[r_wbin[A-1:0]] <= wdata;
        end
    end

    // Read domain
    always_comb begin
        w_rpop            = rinc && !r_rempty;
        w_rbin_next       = r_rbin + PW'(w_rpop);
        w_rgray_next      = PW'(bin2gray(32'(w_rbin_next)));
        w_wq2_bin         = PW'(gray2bin(32'(w_wq2)));
        w_rlevel          = w_wq2_bin - w_rbin_next;
        w_rempty_next     = (w_rgray_next == w_wq2);
        w_half_empty_next = (w_rlevel < HALF);
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_rbin       <= '0;
            r_rgray      <= '0;
            r_rempty     <= 1'b1;
            r_half_empty <= 1'b1;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rgray      <= w_rgray_next;
            r_rempty     <= w_rempty_next;
            r_half_empty <= w_half_empty_next;
        end
    end

    assign rdata      = r_mem[r_rbin[A-1:0]];
    assign wfull      = r_wfull;
    assign half_full  = r_half_full;
    assign rempty     = r_rempty;
    assign half_empty = r_half_empty;

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - self-checking bench for async_fifo
module tb_async_fifo;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          wrst = 1'b0;
    logic          rrst = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          wfull;
    logic          half_full;
    logic          rempty;
    logic          half_empty;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb [$];

    async_fifo #(.DATA_LINES(DW), .ADDR_LINES(AW)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .rclk       (rclk),
        .rrst       (rrst),
        .winc       (winc),
        .wdata      (wdata),
        .wfull      (wfull),
        .half_full  (half_full),
        .rinc       (rinc),
        .rdata      (rdata),
        .rempty     (rempty),
        .half_empty (half_empty)
    );

    always #4.165ns wclk = ~wclk;
    always #7.5ns   rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, output bit ok);
        @(negedge wclk);
        ok    = !wfull;
        winc  = 1'b1;
        wdata = d;
        @(negedge wclk);
        winc = 1'b0;
        if (ok) sb.push_back(d);
    endtask

    task automatic pop(input string tag, output bit ok);
        @(negedge rclk);
        ok = !rempty;
        if (ok) chk(tag, 32'(rdata), 32'(sb[0]));
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        if (ok) void'(sb.pop_front());
    endtask

    // After both sides idle long enough, flags must equal the exact occupancy rules.
    task automatic check_flags(input string tag);
        int occ;
        repeat (6) @(negedge rclk);
        occ = sb.size();
        @(negedge wclk);
        chk({tag, "_wfull"},     32'(wfull),      32'(occ == DEPTH));
        chk({tag, "_half_full"}, 32'(half_full),  32'(occ >= DEPTH / 2));
        @(negedge rclk);
        chk({tag, "_rempty"},    32'(rempty),     32'(occ == 0));
        chk({tag, "_half_empty"},32'(half_empty), 32'(occ < DEPTH / 2));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit ok;
    bit ok_w;
    bit ok_r;
    int cnt;
    int acc_w;
    int acc_r;
    int cyc_w;
    int cyc_r;

    initial begin
        // Reset
        repeat (10) @(posedge rclk);
        #1ns;
        chk("rst_hold_rempty",     32'(rempty),     32'd1);
        chk("rst_hold_wfull",      32'(wfull),      32'd0);
        chk("rst_hold_half_full",  32'(half_full),  32'd0);
        chk("rst_hold_half_empty", 32'(half_empty), 32'd1);
        @(negedge wclk) wrst = 1'b1;
        @(negedge rclk) rrst = 1'b1;
        check_flags("rst_rel");

        // Single word
        push(8'hA5, ok);
        chk("s2_accept", 32'(ok), 32'd1);
        cnt = 0;
        while (rempty && cnt < 3) begin
            @(posedge rclk);
            #1ns;
            cnt++;
        end
        chk("s2_rempty_fall", 32'(rempty), 32'd0);
        chk("s2_rdata_fwft",  32'(rdata),  32'hA5);
        pop("s2_pop_data", ok);
        chk("s2_pop_ok",         32'(ok),         32'd1);
        chk("s2_rempty_again",   32'(rempty),     32'd1);
        chk("s2_half_empty",     32'(half_empty), 32'd1);
        check_flags("s2_idle");

        // Fill
        for (int i = 0; i < DEPTH; i++) begin
            push(8'($urandom), ok);
            chk("fill_accept",    32'(ok),        32'd1);
            chk("fill_half_full", 32'(half_full), 32'(i + 1 >= DEPTH / 2));
            chk("fill_wfull",     32'(wfull),     32'(i == DEPTH - 1));
        end
        push(8'h5A, ok);
        chk("fill_257_rejected", 32'(ok),    32'd0);
        chk("fill_257_wfull",    32'(wfull), 32'd1);
        check_flags("full");

        // Drain
        for (int i = 0; i < DEPTH; i++) begin
            pop("drain_data", ok);
            chk("drain_nonempty",   32'(ok),         32'd1);
            chk("drain_half_empty", 32'(half_empty), 32'(sb.size() < DEPTH / 2));
            chk("drain_rempty",     32'(rempty),     32'(sb.size() == 0));
        end
        check_flags("drained");

        // Streaming bursts
        for (int b = 0; b < 2; b++) begin
            fork
                begin
                    repeat (125) begin
                        push(8'($urandom), ok_w);
                        chk("stream_no_overflow", 32'(ok_w), 32'd1);
                    end
                end
                begin
                    repeat (125) pop("stream_data", ok_r);
                end
            join
            #1us;
        end
        cnt = 0;
        while (sb.size() > 0 && cnt < 400) begin
            pop("stream_tail_data", ok);
            cnt++;
        end
        chk("stream_tail_drained", 32'(sb.size()), 32'd0);
        check_flags("stream_end");

        // Wrap: writer outruns reader, so full back-pressure is exercised across pointer laps
        acc_w = 0; acc_r = 0; cyc_w = 0; cyc_r = 0;
        fork
            begin
                while (acc_w < 700 && cyc_w < 6000) begin
                    push(8'($urandom), ok_w);
                    if (ok_w) acc_w++;
                    cyc_w++;
                    if ($urandom_range(3) == 0) @(negedge wclk);
                end
            end
            begin
                while (acc_r < 700 && cyc_r < 4000) begin
                    pop("wrap_data", ok_r);
                    if (ok_r) acc_r++;
                    cyc_r++;
                    if ($urandom_range(3) == 0) @(negedge rclk);
                end
            end
        join
        chk("wrap_written", 32'(acc_w), 32'd700);
        chk("wrap_read",    32'(acc_r), 32'd700);
        check_flags("wrap_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
